// File: rtl/pipelined_cpa.sv
// Segmented carry-propagate adder. Each stage adds SEG bits and passes its
// carry on. Every stage register rotates right by SEG, so the unconsumed
// operand bits move down and the finished sum slices fill in from the top.
// Optional macro PIPELINED_CPA_OVF_EN adds a signed-overflow flag. The
// operand MSBs travel through the pipeline alongside the data.
module pipelined_cpa #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG_NZ = (SEG == 0) ? 1 : SEG;
  localparam int unsigned NSEG   = (WIDTH / SEG_NZ == 0) ? 1 : WIDTH / SEG_NZ;

  // Reject geometries that cannot be split into whole segments
  if ((WIDTH < 1) || (SEG < 1) || ((WIDTH % SEG_NZ) != 0)) begin : g_bad_cfg
    $error("pipelined_cpa: WIDTH must be a positive multiple of SEG");
  end

  logic [WIDTH-1:0] x_in [NSEG];
  logic [WIDTH-1:0] y_in [NSEG];
  logic             c_in [NSEG];
  logic             v_in [NSEG];

  logic [WIDTH-1:0] x_d  [NSEG];
  logic [WIDTH-1:0] y_d  [NSEG];
  logic             c_d  [NSEG];

  logic [WIDTH-1:0] x_q  [NSEG];
  logic [WIDTH-1:0] y_q  [NSEG];
  logic             c_q  [NSEG];
  logic             v_q  [NSEG];

  logic [SEG:0]     slice;
  logic             adv;

  // Whole pipeline moves only when the output slot is free or being drained
  assign adv      = !v_q[NSEG-1] || out_ready;
  assign in_ready = adv;

  // Stage k reads the primary inputs for k=0, otherwise stage k-1's registers
  always_comb begin
    x_in[0] = a;
    y_in[0] = b;
    c_in[0] = cin;
    v_in[0] = in_valid;
    for (int k = 1; k < int'(NSEG); k++) begin
      x_in[k] = x_q[k-1];
      y_in[k] = y_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  // Per-stage SEG-bit add; the result slice is rotated in at the top
  always_comb begin
    slice = '0;
    x_d   = '{default: '0};
    y_d   = '{default: '0};
    c_d   = '{default: 1'b0};
    for (int k = 0; k < int'(NSEG); k++) begin
      slice  = {1'b0, x_in[k][SEG-1:0]} + {1'b0, y_in[k][SEG-1:0]}
             + (SEG+1)'(c_in[k]);
      x_d[k] = (x_in[k] >> SEG) | (WIDTH'(slice[SEG-1:0]) << (WIDTH - SEG));
      y_d[k] = y_in[k] >> SEG;
      c_d[k] = slice[SEG];
    end
  end

  // Stage registers; a held output freezes every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_in[k];
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign sum       = x_q[NSEG-1];
  assign cout      = c_q[NSEG-1];

`ifdef PIPELINED_CPA_OVF_EN
  logic am_in [NSEG];
  logic bm_in [NSEG];
  logic am_q  [NSEG];
  logic bm_q  [NSEG];

  // Operand sign bits follow their transaction through the stages
  always_comb begin
    am_in[0] = a[WIDTH-1];
    bm_in[0] = b[WIDTH-1];
    for (int k = 1; k < int'(NSEG); k++) begin
      am_in[k] = am_q[k-1];
      bm_in[k] = bm_q[k-1];
    end
  end

  // Sign-bit pipeline registers, stalled together with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        am_q[k] <= 1'b0;
        bm_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        am_q[k] <= am_in[k];
        bm_q[k] <= bm_in[k];
      end
    end
  end

  assign ovf = (am_q[NSEG-1] == bm_q[NSEG-1]) && (sum[WIDTH-1] != am_q[NSEG-1]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa (WIDTH=16, SEG=4): a queue model of accepted
// transactions checked every cycle, plus directed literal expectations.
module tb_pipelined_cpa;

  localparam int unsigned W    = 16;
  localparam int unsigned S    = 4;
  localparam int          NSEG = 4;
`ifdef PIPELINED_CPA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           left;
  } exp_t;

  exp_t q[$];
  bit   m_ev;

  pipelined_cpa #(.WIDTH(W), .SEG(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic cc);
    exp_t        e;
    logic [W:0]  t;
    t      = 17'(aa) + 17'(bb) + 17'(cc);
    e.s    = t[W-1:0];
    e.c    = t[W];
    e.o    = OVF_EN && (aa[W-1] == bb[W-1]) && (t[W-1] != aa[W-1]);
    e.left = NSEG - 1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each accepted transaction emerges after NSEG advancing edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_ev = (q.size() > 0) && (q[0].left == 0);
      if (!m_ev || out_ready) begin
        if (m_ev) void'(q.pop_front());
        foreach (q[i]) if (q[i].left > 0) q[i].left = q[i].left - 1;
        if (in_valid) q.push_back(model(a, b, cin));
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0) && (q[0].left == 0);
    check("in_ready", 32'(in_ready), 32'(!ev || out_ready));
    check("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      check("model_sum", 32'(sum), 32'(q[0].s));
      check("model_cout", 32'(cout), 32'(q[0].c));
      check("model_ovf", 32'(ovf), 32'(q[0].o));
    end
  end

  task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    cin      = cc;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Full-width wrap: FFFF + 1
    drive(16'hFFFF, 16'h0001, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("wrap_early_valid", 32'(out_valid), 32'h0);
    tick();
    check("wrap_valid", 32'(out_valid), 32'h1);
    check("wrap_sum", 32'(sum), 32'h0000);
    check("wrap_cout", 32'(cout), 32'h1);
    tick();
    check("wrap_drained", 32'(out_valid), 32'h0);

    // Back-to-back transactions, results on consecutive cycles
    drive(16'h0001, 16'h0002, 1'b0);     tick();
    drive(16'h00FF, 16'h0001, 1'b0);     tick();
    drive(16'h0F0F, 16'hF0F0, 1'b1);     tick();
    in_valid = 1'b0;
    tick();
    check("b2b_sum0", 32'(sum), 32'h0003);
    check("b2b_cout0", 32'(cout), 32'h0);
    tick();
    check("b2b_sum1", 32'(sum), 32'h0100);
    check("b2b_valid1", 32'(out_valid), 32'h1);
    tick();
    check("b2b_sum2", 32'(sum), 32'h0000);
    check("b2b_cout2", 32'(cout), 32'h1);
    tick();
    check("b2b_drained", 32'(out_valid), 32'h0);

    // Carry-in only
    drive(16'h0000, 16'h0000, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("cin_sum", 32'(sum), 32'h0001);
    check("cin_cout", 32'(cout), 32'h0);
    tick();

    // Signed overflow
    drive(16'h7FFF, 16'h0001, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("ovf_sum", 32'(sum), 32'h8000);
    check("ovf_flag", 32'(ovf), 32'(OVF_EN));
    check("ovf_cout", 32'(cout), 32'h0);
    tick();

    // Output stall for 3 cycles with a pending input
    drive(16'h000A, 16'h0014, 1'b0);     tick();
    drive(16'h0100, 16'h0200, 1'b0);     tick();
    drive(16'h1234, 16'h1111, 1'b0);     tick();
    in_valid = 1'b0;
    tick();
    check("stall_first", 32'(sum), 32'h001E);
    out_ready = 1'b0;
    drive(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_sum", 32'(sum), 32'h001E);
      check("stall_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("release_sum1", 32'(sum), 32'h0300);
    tick();
    check("release_sum2", 32'(sum), 32'h2345);
    tick();
    check("release_bubble", 32'(out_valid), 32'h0);
    tick();
    check("release_sum3", 32'(sum), 32'h0000);
    check("release_cout3", 32'(cout), 32'h1);
    tick();
    check("release_drained", 32'(out_valid), 32'h0);

    // Reset two cycles after acceptance discards the transaction
    drive(16'h1111, 16'h2222, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_stale", 32'(out_valid), 32'h0);
    end

    // Mixed bubbles and back-pressure, checked by the model
    for (int i = 0; i < 24; i++) begin
      in_valid  = (i % 3) != 2;
      out_ready = (i % 5) != 4;
      a         = 16'(i * 4919);
      b         = 16'(65535 - i * 3);
      cin       = 1'(i & 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("final_drained", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
